pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Sequential successor to the combinational next-PC logic; owns the PC register for the single-cycle MIPS core.
- Computes next PC for sequential flow, BEQ/BNE, J/JAL and JR/JALR, plus exception entry and ERET return.
- Holds an internal return-address stack (RAS) that predicts and checks JR targets.
- Sits between instruction memory (drives `pc`) and the decode/ALU stage (consumes op, funct, aluout, rs_value).

Parameters:
- WIDTH, 32, PC/data width. Must be ≥32; bits above 27 are kept from the current PC on J/JAL.
- RESET_PC, 32'h0000_3000, PC value after reset.
- EXC_VECTOR, 32'h0000_4180, exception entry address.
- RAS_DEPTH, 4, number of return-address stack entries. Power of two, ≥2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- en  in  1  advance enable; 0 = hold PC (stall)
- op  in  6  instruction opcode
- funct  in  6  function field (used when op=000000)
- branch_delta  in  16  branch offset in words
- jump_target  in  26  J/JAL target field
- aluout  in  WIDTH  rs−rt result; zero means equal
- rs_value  in  WIDTH  rs register value (JR/JALR target)
- exc_req  in  1  exception request
- eret  in  1  return-from-exception request
- pc  out  WIDTH  current PC (registered)
- pc_plus4  out  WIDTH  pc+4 (combinational); also the link value for JAL/JALR
- epc  out  WIDTH  saved exception PC (registered)
- ras_top  out  WIDTH  top RAS entry (0 when empty)
- ras_valid  out  1  RAS non-empty
- ras_overflow  out  1  sticky; set when a push overwrites the oldest entry
- ras_mismatch  out  1  one-cycle pulse on a JR target mispredict

Behaviour:
- Reset (async, any time, including mid-operation):
  - pc=RESET_PC, epc=0.
  - RAS count=0, pointer=0, all entries=0.
  - ras_overflow=0, ras_mismatch=0.
- Register update priority each rising edge: exc_req > eret > !en (hold) > instruction decode.
- exc_req: pc<=EXC_VECTOR, epc<=pc. Acts regardless of en. Wins over a simultaneous eret. No RAS change.
- eret (no exc_req): pc<=epc. Acts regardless of en. No RAS change.
- en=0: pc, epc and RAS hold. ras_mismatch drives 0.
- Decode when en=1:
  - BEQ (000100): pc<=pc+4+off if aluout==0, else pc+4.
  - BNE (000101): pc<=pc+4+off if aluout!=0, else pc+4.
  - off = sign-extend(branch_delta) shifted left 2, extended to WIDTH. All sums wrap modulo 2^WIDTH.
  - J (000010): pc<={pc[WIDTH-1:28], jump_target, 2'b00}.
  - JAL (000011): same target as J; push pc+4 onto RAS.
  - op=000000, funct=001000 (JR): pc<=rs_value; pop RAS.
  - op=000000, funct=001001 (JALR): pc<=rs_value; push pc+4. No pop.
  - Any other op/funct: pc<=pc+4.
- RAS:
  - Circular buffer with a top pointer and a count saturating at RAS_DEPTH.
  - Push when full: overwrite the oldest entry, count stays RAS_DEPTH, ras_overflow<=1 (sticky until reset).
  - Pop when empty: no state change, no mismatch pulse.
  - ras_top and ras_valid reflect current registered state.
- ras_mismatch: registered. Equals 1 for exactly the cycle after a JR executes with ras_valid=1 and rs_value!=ras_top; otherwise 0. The JR still jumps to rs_value; the RAS is advisory only.
- Latency: pc updates one cycle after inputs are sampled. pc_plus4 is combinational from pc.

Decomposition:
- Shared package mips_pkg:
  - opcode constants OP_SPECIAL, OP_BEQ, OP_BNE, OP_J, OP_JAL
  - funct constants FN_JR, FN_JALR
  - default RESET_PC and EXC_VECTOR
- Sub-module ras_stack:
  - parameters WIDTH, RAS_DEPTH
  - ports clk, rst, push, pop, push_data, top, valid, overflow
- pc_unit instantiates one ras_stack and contains the next-PC mux and the pc/epc registers.

Test Plan:
- Reset and sequential flow: assert rst mid-run, then release with no control ops → pc=32'h3000, then 3004, then 3008.
- Backward branch and not-taken branch: at pc=32'h3010, BEQ with aluout=0 and branch_delta=16'hFFFC → pc=32'h3004. BNE with aluout=0 → pc=32'h3014.
- Calls and returns with mismatch: at pc=32'h3000, JAL with jump_target=26'h0000C40 → pc=32'h3100, ras_top=32'h3004. Then JR with rs_value=32'h3004 → pc=32'h3004, no mismatch. Then JAL followed by JR with rs_value=32'h5000 → ras_mismatch pulses 1 for one cycle.
- RAS overflow (RAS_DEPTH=4): 5 consecutive JALs → ras_overflow=1 and count stays 4. Then 4 JRs empty the stack; a 5th JR → ras_valid=0, no mismatch pulse.
- Exception and ERET: exc_req at pc=32'h3020 with en=0 → pc=32'h4180, epc=32'h3020. Then eret → pc=32'h3020. exc_req and eret in the same cycle → exception taken.
- Stall: en=0 for 3 cycles during a BEQ-taken instruction → pc holds. The branch resolves on the first cycle with en=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encodings and default addresses for the PC datapath.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push onto a full stack overwrites the oldest entry.
module ras_stack #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             valid,
  output logic             overflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;

  assign ptr_inc = ptr_q + PTR_ONE;
  assign ptr_dec = ptr_q - PTR_ONE;

  // The pointer wraps naturally because RAS_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (push) begin
      mem_q[ptr_inc] <= push_data;
      ptr_q          <= ptr_inc;
      if (cnt_q == CNT_FULL) ovf_q <= 1'b1;
      else                   cnt_q <= cnt_q + CNT_ONE;
    end else if (pop && (cnt_q != '0)) begin
      ptr_q <= ptr_dec;
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

  assign valid    = (cnt_q != '0);
  assign top      = valid ? mem_q[ptr_q] : '0;
  assign overflow = ovf_q;

endmodule

// File: rtl/pc_unit.sv
// PC register and next-PC selection for the single-cycle MIPS core,
// with exception entry/return and a return-address stack checking JR targets.
module pc_unit
  import mips_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(RESET_PC_DEF),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(EXC_VECTOR_DEF),
  parameter int               RAS_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic [15:0]      branch_delta,
  input  logic [25:0]      jump_target,
  input  logic [WIDTH-1:0] aluout,
  input  logic [WIDTH-1:0] rs_value,
  input  logic             exc_req,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_valid,
  output logic             ras_overflow,
  output logic             ras_mismatch
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             mism_q, mism_d;
  logic             ras_push, ras_pop;
  logic [WIDTH-1:0] br_off, br_tgt, j_tgt;

  assign pc_plus4 = pc_q + WIDTH'(4);
  assign br_off   = {{(WIDTH-18){branch_delta[15]}}, branch_delta, 2'b00};
  assign br_tgt   = pc_plus4 + br_off;
  assign j_tgt    = {pc_q[WIDTH-1:28], jump_target, 2'b00};

  always_comb begin
    pc_d     = pc_q;
    epc_d    = epc_q;
    mism_d   = 1'b0;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (exc_req) begin
      pc_d  = EXC_VECTOR;
      epc_d = pc_q;
    end else if (eret) begin
      pc_d = epc_q;
    end else if (en) begin
      pc_d = pc_plus4;
      case (op)
        OP_BEQ: if (aluout == '0) pc_d = br_tgt;
        OP_BNE: if (aluout != '0) pc_d = br_tgt;
        OP_J:   pc_d = j_tgt;
        OP_JAL: begin
          pc_d     = j_tgt;
          ras_push = 1'b1;
        end
        OP_SPECIAL: begin
          if (funct == FN_JR) begin
            pc_d    = rs_value;
            ras_pop = 1'b1;
            // Prediction is advisory: flag it, but still follow rs_value.
            mism_d  = ras_valid && (rs_value != ras_top);
          end else if (funct == FN_JALR) begin
            pc_d     = rs_value;
            ras_push = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      epc_q  <= '0;
      mism_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      epc_q  <= epc_d;
      mism_q <= mism_d;
    end
  end

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .valid     (ras_valid),
    .overflow  (ras_overflow)
  );

  assign pc           = pc_q;
  assign epc          = epc_q;
  assign ras_mismatch = mism_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit.
module tb_pc_unit;

  logic        clk;
  logic        rst;
  logic        en;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [15:0] branch_delta;
  logic [25:0] jump_target;
  logic [31:0] aluout;
  logic [31:0] rs_value;
  logic        exc_req;
  logic        eret;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] epc;
  logic [31:0] ras_top;
  logic        ras_valid;
  logic        ras_overflow;
  logic        ras_mismatch;

  int checks = 0;
  int errors = 0;

  pc_unit dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .op           (op),
    .funct        (funct),
    .branch_delta (branch_delta),
    .jump_target  (jump_target),
    .aluout       (aluout),
    .rs_value     (rs_value),
    .exc_req      (exc_req),
    .eret         (eret),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .epc          (epc),
    .ras_top      (ras_top),
    .ras_valid    (ras_valid),
    .ras_overflow (ras_overflow),
    .ras_mismatch (ras_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b1; op = 6'b000000; funct = 6'b000000; branch_delta = 16'h0000;
    jump_target = 26'h0; aluout = 32'h0; rs_value = 32'h0; exc_req = 1'b0; eret = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  task automatic go_to(input logic [31:0] addr);
    idle();
    do_reset();
    repeat ((addr - 32'h3000) / 4) step();
  endtask

  task automatic jal(input logic [25:0] jt);
    op = 6'b000011; jump_target = jt; step(); idle();
  endtask

  task automatic jr(input logic [31:0] rs);
    op = 6'b000000; funct = 6'b001000; rs_value = rs; step(); idle();
  endtask

  task automatic test_reset();
    idle();
    repeat (3) step();
    exc_req = 1'b1; step(); idle();
    jal(26'h0000C40);
    checks++; if (ras_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", ras_valid); end
    rst = 1'b1;
    #1;
    checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL async_reset_pc: got %h expected 00003000", pc); end
    checks++; if (epc !== 32'h0) begin errors++; $display("FAIL async_reset_epc: got %h expected 00000000", epc); end
    checks++; if (ras_valid !== 1'b0 || ras_top !== 32'h0) begin errors++; $display("FAIL async_reset_ras: got valid=%b top=%h expected 0/00000000", ras_valid, ras_top); end
    checks++; if (ras_overflow !== 1'b0 || ras_mismatch !== 1'b0) begin errors++; $display("FAIL async_reset_flags: got ovf=%b mis=%b expected 0/0", ras_overflow, ras_mismatch); end
    rst = 1'b0;
    step();
    checks++; if (pc !== 32'h3004) begin errors++; $display("FAIL seq_1: got %h expected 00003004", pc); end
    step();
    checks++; if (pc !== 32'h3008 || pc_plus4 !== 32'h300C) begin errors++; $display("FAIL seq_2: got pc=%h pc4=%h expected 00003008/0000300c", pc, pc_plus4); end
  endtask

  task automatic test_branch();
    go_to(32'h3010);
    checks++; if (pc !== 32'h3010) begin errors++; $display("FAIL reach_3010: got %h expected 00003010", pc); end
    op = 6'b000100; aluout = 32'h0; branch_delta = 16'hFFFC; step(); idle();
    checks++; if (pc !== 32'h3004) begin errors++; $display("FAIL beq_back: got %h expected 00003004", pc); end
    go_to(32'h3010);
    op = 6'b000101; aluout = 32'h0; branch_delta = 16'hFFFC; step(); idle();
    checks++; if (pc !== 32'h3014) begin errors++; $display("FAIL bne_not_taken: got %h expected 00003014", pc); end
    op = 6'b000101; aluout = 32'h1; branch_delta = 16'h0003; step(); idle();
    checks++; if (pc !== 32'h3024) begin errors++; $display("FAIL bne_taken: got %h expected 00003024", pc); end
    op = 6'b000100; aluout = 32'h7; branch_delta = 16'h0100; step(); idle();
    checks++; if (pc !== 32'h3028) begin errors++; $display("FAIL beq_not_taken: got %h expected 00003028", pc); end
  endtask

  task automatic test_calls();
    go_to(32'h3000);
    jal(26'h0000C40);
    checks++; if (pc !== 32'h3100 || ras_top !== 32'h3004 || ras_valid !== 1'b1) begin errors++; $display("FAIL jal_push: got pc=%h top=%h valid=%b expected 00003100/00003004/1", pc, ras_top, ras_valid); end
    jr(32'h3004);
    checks++; if (pc !== 32'h3004 || ras_mismatch !== 1'b0 || ras_valid !== 1'b0) begin errors++; $display("FAIL jr_hit: got pc=%h mis=%b valid=%b expected 00003004/0/0", pc, ras_mismatch, ras_valid); end
    jal(26'h0000C40);
    checks++; if (ras_top !== 32'h3008) begin errors++; $display("FAIL jal2_top: got %h expected 00003008", ras_top); end
    jr(32'h5000);
    checks++; if (pc !== 32'h5000 || ras_mismatch !== 1'b1) begin errors++; $display("FAIL jr_miss: got pc=%h mis=%b expected 00005000/1", pc, ras_mismatch); end
    step();
    checks++; if (pc !== 32'h5004 || ras_mismatch !== 1'b0) begin errors++; $display("FAIL mis_pulse_end: got pc=%h mis=%b expected 00005004/0", pc, ras_mismatch); end
    op = 6'b000000; funct = 6'b001001; rs_value = 32'h6000; step(); idle();
    checks++; if (pc !== 32'h6000 || ras_top !== 32'h5008 || ras_valid !== 1'b1) begin errors++; $display("FAIL jalr: got pc=%h top=%h valid=%b expected 00006000/00005008/1", pc, ras_top, ras_valid); end
    jr(32'h5008);
    checks++; if (ras_mismatch !== 1'b0 || ras_valid !== 1'b0) begin errors++; $display("FAIL jr_after_jalr: got mis=%b valid=%b expected 0/0", ras_mismatch, ras_valid); end
    jr(32'hA000_0000);
    checks++; if (pc !== 32'hA000_0000 || ras_mismatch !== 1'b0) begin errors++; $display("FAIL jr_empty: got pc=%h mis=%b expected a0000000/0", pc, ras_mismatch); end
    op = 6'b000010; jump_target = 26'h0000010; step(); idle();
    checks++; if (pc !== 32'hA000_0040) begin errors++; $display("FAIL j_upper_bits: got %h expected a0000040", pc); end
  endtask

  task automatic test_overflow();
    logic [25:0] jts [5];
    jts[0] = 26'h0C40; jts[1] = 26'h0C80; jts[2] = 26'h0CC0; jts[3] = 26'h0D00; jts[4] = 26'h0D40;
    go_to(32'h3000);
    for (int i = 0; i < 4; i++) jal(jts[i]);
    checks++; if (ras_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", ras_overflow); end
    jal(jts[4]);
    checks++; if (ras_overflow !== 1'b1 || ras_top !== 32'h3404 || pc !== 32'h3500) begin errors++; $display("FAIL ovf_set: got ovf=%b top=%h pc=%h expected 1/00003404/00003500", ras_overflow, ras_top, pc); end
    jr(32'h3404);
    jr(32'h3304);
    jr(32'h3204);
    checks++; if (ras_top !== 32'h3104 || ras_valid !== 1'b1 || ras_mismatch !== 1'b0) begin errors++; $display("FAIL ovf_pop3: got top=%h valid=%b mis=%b expected 00003104/1/0", ras_top, ras_valid, ras_mismatch); end
    jr(32'h3104);
    checks++; if (ras_valid !== 1'b0 || ras_top !== 32'h0 || ras_mismatch !== 1'b0) begin errors++; $display("FAIL ovf_pop4: got valid=%b top=%h mis=%b expected 0/00000000/0", ras_valid, ras_top, ras_mismatch); end
    jr(32'h3004);
    checks++; if (ras_valid !== 1'b0 || ras_mismatch !== 1'b0 || ras_overflow !== 1'b1 || pc !== 32'h3004) begin errors++; $display("FAIL ovf_pop5: got valid=%b mis=%b ovf=%b pc=%h expected 0/0/1/00003004", ras_valid, ras_mismatch, ras_overflow, pc); end
  endtask

  task automatic test_exception();
    go_to(32'h3020);
    en = 1'b0; exc_req = 1'b1; step(); idle();
    checks++; if (pc !== 32'h4180 || epc !== 32'h3020) begin errors++; $display("FAIL exc_entry: got pc=%h epc=%h expected 00004180/00003020", pc, epc); end
    eret = 1'b1; step(); idle();
    checks++; if (pc !== 32'h3020 || epc !== 32'h3020) begin errors++; $display("FAIL eret: got pc=%h epc=%h expected 00003020/00003020", pc, epc); end
    exc_req = 1'b1; eret = 1'b1; op = 6'b000011; jump_target = 26'h0C40; step(); idle();
    checks++; if (pc !== 32'h4180 || epc !== 32'h3020 || ras_valid !== 1'b0) begin errors++; $display("FAIL exc_over_eret: got pc=%h epc=%h valid=%b expected 00004180/00003020/0", pc, epc, ras_valid); end
    step();
    checks++; if (pc !== 32'h4184) begin errors++; $display("FAIL exc_handler_seq: got %h expected 00004184", pc); end
    en = 1'b0; eret = 1'b1; step(); idle();
    checks++; if (pc !== 32'h3020) begin errors++; $display("FAIL eret_stalled: got %h expected 00003020", pc); end
  endtask

  task automatic test_stall();
    go_to(32'h3010);
    op = 6'b000100; aluout = 32'h0; branch_delta = 16'hFFFC; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== 32'h3010) begin errors++; $display("FAIL stall_hold_%0d: got %h expected 00003010", i, pc); end
    end
    en = 1'b1; step(); idle();
    checks++; if (pc !== 32'h3004) begin errors++; $display("FAIL stall_resolve: got %h expected 00003004", pc); end
    go_to(32'h3000);
    jal(26'h0000C40);
    op = 6'b000000; funct = 6'b001000; rs_value = 32'h5000; en = 1'b0; step();
    checks++; if (pc !== 32'h3100 || ras_mismatch !== 1'b0 || ras_valid !== 1'b1 || ras_top !== 32'h3004) begin errors++; $display("FAIL stall_jr: got pc=%h mis=%b valid=%b top=%h expected 00003100/0/1/00003004", pc, ras_mismatch, ras_valid, ras_top); end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    test_reset();
    test_branch();
    test_calls();
    test_overflow();
    test_exception();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
